// File: rtl/encoder_line_trigger.sv
// Line-trigger source: quadrature encoder (sync, glitch filter, x4 decode, divider) or period timer,
// driving a fixed-width pulse generator with line, lost-trigger and position counters.
module encoder_line_trigger #(
    parameter int FILT_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_line_trigger_en,
    input  logic              reg_trigger_mode,
    input  logic [31:0]       reg_timer_period,
    input  logic [DIV_W-1:0]  reg_encoder_div,
    input  logic              reg_encoder_dir,
    input  logic [FILT_W-1:0] reg_filter_len,
    input  logic [31:0]       reg_line_trigger_width,
    input  logic              reg_line_trigger_polar,
    input  logic              reg_pos_clr,
    input  logic              encoder_a,
    input  logic              encoder_b,
    output logic              line_trigger,
    output logic [31:0]       reg_line_trigger_cnt,
    output logic [15:0]       reg_line_trigger_lost,
    output logic [31:0]       encoder_pos,
    output logic              encoder_err
);
    localparam logic [FILT_W-1:0]       FILT_ZERO = {FILT_W{1'b0}};
    localparam logic [FILT_W-1:0]       FILT_ONE  = {{(FILT_W-1){1'b0}}, 1'b1};
    localparam logic signed [DIV_W:0]   ACC_ZERO  = {(DIV_W+1){1'b0}};
    localparam logic signed [DIV_W:0]   ACC_ONE   = {{DIV_W{1'b0}}, 1'b1};
    localparam logic signed [DIV_W:0]   ACC_MIN   = {1'b1, {DIV_W{1'b0}}};

    // Maps a Gray-coded {A,B} pair onto its position in the forward cycle 00->01->11->10.
    function automatic logic [1:0] f_phase(input logic [1:0] ab);
        logic [1:0] ph;
        case (ab)
            2'b00:   ph = 2'd0;
            2'b01:   ph = 2'd1;
            2'b11:   ph = 2'd2;
            default: ph = 2'd3;
        endcase
        return ph;
    endfunction

    logic [1:0]              r_a_sync;
    logic [1:0]              r_b_sync;
    logic [1:0]              w_sync;
    logic [1:0]              r_filt;
    logic [1:0]              r_filt_d;
    logic [FILT_W-1:0]       r_fcnt [2];
    logic [1:0]              w_delta;
    logic                    w_fwd;
    logic                    w_rev;
    logic                    w_ill;
    logic [31:0]             r_pos;
    logic                    r_err;
    logic                    r_mode_d;
    logic                    w_mode_chg;
    logic                    w_cnt_step;
    logic                    w_opp_step;
    logic signed [DIV_W:0]   r_acc;
    logic signed [DIV_W:0]   w_acc_nxt;
    logic signed [DIV_W:0]   w_acc_inc;
    logic signed [DIV_W:0]   w_acc_tgt;
    logic                    w_div_hit;
    logic [31:0]             r_tmr;
    logic [31:0]             w_tmr_nxt;
    logic [31:0]             w_period_m1;
    logic                    w_tmr_hit;
    logic                    w_req_nxt;
    logic                    r_req;
    logic [31:0]             r_pulse_cnt;
    logic [31:0]             w_width_ld;
    logic                    w_pulse_busy;
    logic [31:0]             r_line_cnt;
    logic [15:0]             r_lost;
    logic                    r_line;

    // Two-flop synchronisers for the asynchronous encoder pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sync <= 2'b00;
            r_b_sync <= 2'b00;
        end else begin
            r_a_sync <= {r_a_sync[0], encoder_a};
            r_b_sync <= {r_b_sync[0], encoder_b};
        end
    end

    assign w_sync = {r_a_sync[1], r_b_sync[1]};

    // Per-pin glitch filter: output follows only after len+1 consecutive differing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_filt    <= 2'b00;
            r_fcnt[0] <= FILT_ZERO;
            r_fcnt[1] <= FILT_ZERO;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_sync[i] != r_filt[i]) begin
                    if (r_fcnt[i] >= reg_filter_len) begin
                        r_filt[i] <= w_sync[i];
                        r_fcnt[i] <= FILT_ZERO;
                    end else begin
                        r_fcnt[i] <= r_fcnt[i] + FILT_ONE;
                    end
                end else begin
                    r_fcnt[i] <= FILT_ZERO;
                end
            end
        end
    end

    assign w_delta = f_phase(r_filt) - f_phase(r_filt_d);
    assign w_fwd   = (w_delta == 2'd1);
    assign w_rev   = (w_delta == 2'd3);
    assign w_ill   = (w_delta == 2'd2);

    // Position counter runs independently of enable/mode; clear takes priority over a step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_filt_d <= 2'b00;
            r_pos    <= 32'd0;
            r_err    <= 1'b0;
        end else begin
            r_filt_d <= r_filt;
            if (reg_pos_clr) begin
                r_pos <= 32'd0;
            end else if (w_fwd) begin
                r_pos <= r_pos + 32'd1;
            end else if (w_rev) begin
                r_pos <= r_pos - 32'd1;
            end
            if (!reg_line_trigger_en) begin
                r_err <= 1'b0;
            end else if (w_ill) begin
                r_err <= 1'b1;
            end
        end
    end

    assign w_mode_chg  = (reg_trigger_mode != r_mode_d);
    assign w_cnt_step  = reg_encoder_dir ? w_rev : w_fwd;
    assign w_opp_step  = reg_encoder_dir ? w_fwd : w_rev;
    assign w_acc_tgt   = (reg_encoder_div == {DIV_W{1'b0}}) ? ACC_ONE : {1'b0, reg_encoder_div};
    assign w_acc_inc   = r_acc + ACC_ONE;
    assign w_period_m1 = reg_timer_period - 32'd1;

    // Divider: opposite steps pull the accumulator negative so backlash must be undone first.
    always_comb begin
        w_acc_nxt = r_acc;
        w_div_hit = 1'b0;
        if (!reg_line_trigger_en || !reg_trigger_mode || w_mode_chg) begin
            w_acc_nxt = ACC_ZERO;
        end else if (w_cnt_step) begin
            if (w_acc_inc >= w_acc_tgt) begin
                w_acc_nxt = ACC_ZERO;
                w_div_hit = 1'b1;
            end else begin
                w_acc_nxt = w_acc_inc;
            end
        end else if (w_opp_step && (r_acc != ACC_MIN)) begin
            w_acc_nxt = r_acc - ACC_ONE;
        end else begin
            w_acc_nxt = r_acc;
        end
    end

    // Period timer: request on the last count of each period, zero period never fires.
    always_comb begin
        w_tmr_nxt = r_tmr;
        w_tmr_hit = 1'b0;
        if (!reg_line_trigger_en || reg_trigger_mode || w_mode_chg ||
            (reg_timer_period == 32'd0)) begin
            w_tmr_nxt = 32'd0;
        end else if (r_tmr >= w_period_m1) begin
            w_tmr_nxt = 32'd0;
            w_tmr_hit = 1'b1;
        end else begin
            w_tmr_nxt = r_tmr + 32'd1;
        end
    end

    assign w_req_nxt = reg_line_trigger_en & (reg_trigger_mode ? w_div_hit : w_tmr_hit);

    // Source state and the registered trigger request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode_d <= 1'b0;
            r_acc    <= ACC_ZERO;
            r_tmr    <= 32'd0;
            r_req    <= 1'b0;
        end else begin
            r_mode_d <= reg_trigger_mode;
            r_acc    <= w_acc_nxt;
            r_tmr    <= w_tmr_nxt;
            r_req    <= w_req_nxt;
        end
    end

    assign w_width_ld   = (reg_line_trigger_width == 32'd0) ? 32'd1 : reg_line_trigger_width;
    assign w_pulse_busy = (r_pulse_cnt != 32'd0);

    // Pulse generator: a request arriving while a pulse runs is dropped and counted as lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pulse_cnt <= 32'd0;
            r_line_cnt  <= 32'd0;
            r_lost      <= 16'd0;
        end else if (!reg_line_trigger_en) begin
            r_pulse_cnt <= 32'd0;
        end else if (r_req && !w_pulse_busy) begin
            r_pulse_cnt <= w_width_ld;
            r_line_cnt  <= r_line_cnt + 32'd1;
        end else begin
            if (w_pulse_busy) begin
                r_pulse_cnt <= r_pulse_cnt - 32'd1;
            end
            if (r_req && (r_lost != 16'hFFFF)) begin
                r_lost <= r_lost + 16'd1;
            end
        end
    end

    // Output stage: idles at the polarity level, goes idle on the first cycle of disable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_line <= 1'b0;
        end else if (reg_line_trigger_en) begin
            r_line <= w_pulse_busy ^ reg_line_trigger_polar;
        end else begin
            r_line <= reg_line_trigger_polar;
        end
    end

    assign line_trigger          = r_line;
    assign reg_line_trigger_cnt  = r_line_cnt;
    assign reg_line_trigger_lost = r_lost;
    assign encoder_pos           = r_pos;
    assign encoder_err           = r_err;

endmodule
